ram_r_bank: RTL and testbench

Single-port-write, registered-read pixel buffer holding the "right" operand samples for the JPEG-2000 5/3 lifting datapath. It is one of three sibling banks: left, odd and right. It exposes the full three-bank bus so every bank has an identical port list. Only the `_r` bus reads and writes this bank by default. A valid-bit array makes never-written entries read as zero after reset.

---
 rtl/ram_bank_pkg.sv | 11 +
 rtl/ram_bank_core.sv | 50 +++++
 rtl/ram_r_bank.sv | 55 +++++
 tb/tb_ram_r_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared sizes and word types for the left/odd/right pixel banks
package ram_bank_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 26;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] pix_addr_t;
  typedef logic [DATA_W-1:0] pix_word_t;

endpackage

// File: rtl/ram_bank_core.sv
// rtl/ram_bank_core.sv - pixel array with valid bits, two write ports (a beats b) and a registered read
module ram_bank_core
  import ram_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wa_en_i,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  pix_word_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  pix_word_t        dout_q;

  // Mark every entry touched by either write port this cycle
  always_comb begin
    valid_d = valid_q;
    if (wb_en_i) valid_d[wb_addr_i] = 1'b1;
    if (wa_en_i) valid_d[wa_addr_i] = 1'b1;
  end

  // Array storage is never cleared; port b is written first so port a wins on equal addresses
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
      if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
    end
  end

  // Valid vector and read register; the read samples pre-write state, giving read-before-write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= valid_q[rd_addr_i] ? mem_q[rd_addr_i] : '0;
    end
  end

  assign rd_data_o = dout_q;

endmodule

// File: rtl/ram_r_bank.sv
// rtl/ram_r_bank.sv - right-operand pixel bank; RAM_R_SNOOP_EN mirrors odd-bank writes into it
module ram_r_bank #(
  parameter int ADDR_W = ram_bank_pkg::ADDR_W,
  parameter int DATA_W = ram_bank_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pix_addr_r,
  input  logic [DATA_W-1:0] pix_din_r,
  input  logic              pix_we_r,
  output logic [DATA_W-1:0] pix_dout_r,
  input  logic [ADDR_W-1:0] pix_addr_odd,
  input  logic [DATA_W-1:0] pix_din_odd,
  input  logic              pix_we_odd,
  input  logic [DATA_W-1:0] pix_dout_odd,
  input  logic [ADDR_W-1:0] pix_addr_l,
  input  logic [DATA_W-1:0] pix_din_l,
  input  logic              pix_we_l,
  input  logic [DATA_W-1:0] pix_dout_l
);

  logic              snoop_en;
  logic [ADDR_W-1:0] snoop_addr;
  logic [DATA_W-1:0] snoop_data;
  logic              unused_ok;

`ifdef RAM_R_SNOOP_EN
  // Odd-sample updates feed the secondary port so this bank stays coherent
  assign snoop_en   = pix_we_odd;
  assign snoop_addr = pix_addr_odd;
  assign snoop_data = pix_din_odd;
  assign unused_ok  = ^{pix_dout_odd, pix_addr_l, pix_din_l, pix_we_l, pix_dout_l};
`else
  // Secondary port idle; the whole odd bus is ignored like the left bus
  assign snoop_en   = 1'b0;
  assign snoop_addr = '0;
  assign snoop_data = '0;
  assign unused_ok  = ^{pix_addr_odd, pix_din_odd, pix_we_odd, pix_dout_odd,
                        pix_addr_l, pix_din_l, pix_we_l, pix_dout_l};
`endif

  ram_bank_core u_core (
    .clk       (clk),
    .rst       (rst),
    .wa_en_i   (pix_we_r),
    .wa_addr_i (pix_addr_r),
    .wa_data_i (pix_din_r),
    .wb_en_i   (snoop_en),
    .wb_addr_i (snoop_addr),
    .wb_data_i (snoop_data),
    .rd_addr_i (pix_addr_r),
    .rd_data_o (pix_dout_r)
  );

endmodule

// File: tb/tb_ram_r_bank.sv
// tb/tb_ram_r_bank.sv - directed and random checks of ram_r_bank against a written-entries map
module tb_ram_r_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  pix_addr_r = '0;
  logic [25:0] pix_din_r = '0;
  logic        pix_we_r = 1'b0;
  logic [25:0] pix_dout_r;
  logic [6:0]  pix_addr_odd = '0;
  logic [25:0] pix_din_odd = '0;
  logic        pix_we_odd = 1'b0;
  logic [25:0] pix_dout_odd = '0;
  logic [6:0]  pix_addr_l = '0;
  logic [25:0] pix_din_l = '0;
  logic        pix_we_l = 1'b0;
  logic [25:0] pix_dout_l = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Map of entries written since the last reset; absent means reads return zero
  logic [25:0] model [int];

  ram_r_bank dut (
    .clk          (clk),
    .rst          (rst),
    .pix_addr_r   (pix_addr_r),
    .pix_din_r    (pix_din_r),
    .pix_we_r     (pix_we_r),
    .pix_dout_r   (pix_dout_r),
    .pix_addr_odd (pix_addr_odd),
    .pix_din_odd  (pix_din_odd),
    .pix_we_odd   (pix_we_odd),
    .pix_dout_odd (pix_dout_odd),
    .pix_addr_l   (pix_addr_l),
    .pix_din_l    (pix_din_l),
    .pix_we_l     (pix_we_l),
    .pix_dout_l   (pix_dout_l)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] lookup(input int a);
    return model.exists(a) ? model[a] : 26'h0;
  endfunction

  // One clock: predict the read, update the map, then compare after the edge
  task automatic step(input string tag);
    logic [25:0] exp;
    exp = rst ? 26'h0 : lookup(int'(pix_addr_r));
    if (rst) begin
      model.delete();
    end else begin
`ifdef RAM_R_SNOOP_EN
      if (pix_we_odd) model[int'(pix_addr_odd)] = pix_din_odd;
`endif
      if (pix_we_r) model[int'(pix_addr_r)] = pix_din_r;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    assert (pix_dout_r === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, pix_dout_r, exp);
    end
  endtask

  // Check the output against a value written straight from the test plan
  task automatic check_const(input string tag, input logic [25:0] exp);
    n_cmp++;
    assert (pix_dout_r === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, pix_dout_r, exp);
    end
  endtask

  task automatic set_r(input int a, input logic [25:0] d, input logic we);
    pix_addr_r = 7'(a);
    pix_din_r  = d;
    pix_we_r   = we;
  endtask

  task automatic set_odd(input int a, input logic [25:0] d, input logic we);
    pix_addr_odd = 7'(a);
    pix_din_odd  = d;
    pix_we_odd   = we;
  endtask

  initial begin
    // Reset and reads of never-written entries
    rst = 1'b1;
    set_r(0, 26'h0, 1'b0);
    step("reset");
    check_const("reset_const", 26'h0);
    rst = 1'b0;
    set_r(0, 26'h0, 1'b0);   step("rd0");   check_const("rd0_zero", 26'h0);
    set_r(5, 26'h0, 1'b0);   step("rd5");   check_const("rd5_zero", 26'h0);
    set_r(127, 26'h0, 1'b0); step("rd127"); check_const("rd127_zero", 26'h0);

    // Write then read next cycle
    set_r(3, 26'h1555555, 1'b1); step("wr3");
    set_r(3, 26'h0, 1'b0);       step("rd3"); check_const("rd3_val", 26'h1555555);

    // Read-before-write at the same address
    set_r(9, 26'h00000AA, 1'b1); step("wr9a");
    set_r(9, 26'h3FFFFFF, 1'b1); step("rbw9"); check_const("rbw9_old", 26'h00000AA);
    set_r(9, 26'h0, 1'b0);       step("rd9");  check_const("rd9_new", 26'h3FFFFFF);

    // Fill, reset, confirm entries are unreadable until rewritten
    for (int i = 0; i < 128; i++) begin
      set_r(i, 26'(i * 3), 1'b1);
      step("fill");
    end
    set_r(10, 26'h0, 1'b0); step("rd10_full"); check_const("rd10_full", 26'd30);
    rst = 1'b1; set_r(30, 26'h1234, 1'b1); step("rst_wr30");
    rst = 1'b0;
    set_r(10, 26'h0, 1'b0); step("rd10_clr"); check_const("rd10_clr", 26'h0);
    set_r(10, 26'd7, 1'b1); step("wr10");
    set_r(10, 26'h0, 1'b0); step("rd10_7");   check_const("rd10_7", 26'd7);
    set_r(30, 26'h0, 1'b0); step("rd30");     check_const("rd30_discard", 26'h0);

    // Sibling bus activity at addr 20 with the right bank idle
    set_r(0, 26'h0, 1'b0);
    pix_addr_l = 7'd20; pix_din_l = 26'h123; pix_we_l = 1'b1;
    set_odd(20, 26'h123, 1'b1);
    step("sib_wr");
    pix_we_l = 1'b0;
    set_odd(0, 26'h0, 1'b0);
    set_r(20, 26'h0, 1'b0); step("rd20_sib");
`ifdef RAM_R_SNOOP_EN
    check_const("rd20_sib", 26'h123);
`else
    check_const("rd20_sib", 26'h0);
`endif

`ifdef RAM_R_SNOOP_EN
    set_odd(20, 26'h222, 1'b1); set_r(0, 26'h0, 1'b0); step("snp20");
    set_odd(0, 26'h0, 1'b0);    set_r(20, 26'h0, 1'b0); step("rd20"); check_const("snp20", 26'h222);
    set_odd(21, 26'h333, 1'b1); set_r(21, 26'h444, 1'b1); step("col21");
    set_odd(0, 26'h0, 1'b0);    set_r(21, 26'h0, 1'b0);   step("rd21"); check_const("col21", 26'h444);
    set_odd(22, 26'h555, 1'b1); set_r(23, 26'h666, 1'b1); step("dual");
    set_odd(0, 26'h0, 1'b0);    set_r(22, 26'h0, 1'b0);   step("rd22"); check_const("dual22", 26'h555);
    set_r(23, 26'h0, 1'b0);     step("rd23"); check_const("dual23", 26'h666);
    rst = 1'b1; set_odd(40, 26'h777, 1'b1); set_r(0, 26'h0, 1'b0); step("rst_snp");
    rst = 1'b0; set_odd(0, 26'h0, 1'b0);    set_r(40, 26'h0, 1'b0); step("rd40"); check_const("rst_snp", 26'h0);
`endif

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_r(int'($urandom_range(0, 15)), 26'($urandom), 1'($urandom_range(0, 1)));
      set_odd(int'($urandom_range(0, 15)), 26'($urandom), 1'($urandom_range(0, 1)));
      pix_addr_l = 7'($urandom_range(0, 15));
      pix_din_l  = 26'($urandom);
      pix_we_l   = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
